// File: rtl/sdr_cmd_monitor.sv
// sdr_cmd_monitor: passive SDRAM command-bus decoder and protocol checker.
// Samples the command pins every rising edge, decodes one command per cycle,
// tracks per-bank open state, flags protocol violations and keeps saturating
// per-command counters. Never drives the DUV.
// Optional build macro: SDR_MON_TIMING_CHK_EN adds per-bank tRCD/tRP timers
// (error codes 3 and 4). Without it those codes are never produced.
module sdr_cmd_monitor #(
  parameter int TRCD  = 3,
  parameter int TRP   = 3,
  parameter int CNT_W = 16
) (
  input  logic             sdram_clk,
  input  logic             sdram_resetn,
  input  logic             sdr_cs_n,
  input  logic             sdr_ras_n,
  input  logic             sdr_cas_n,
  input  logic             sdr_we_n,
  input  logic [1:0]       sdr_ba,
  input  logic [12:0]      sdr_addr,
  input  logic             stat_clr,
  output logic             cmd_valid,
  output logic [2:0]       cmd_code,
  output logic [1:0]       cmd_ba,
  output logic [12:0]      cmd_addr,
  output logic [3:0]       bank_open,
  output logic             err_valid,
  output logic [2:0]       err_code,
  output logic             err_sticky,
  output logic [CNT_W-1:0] cnt_act,
  output logic [CNT_W-1:0] cnt_rd,
  output logic [CNT_W-1:0] cnt_wr,
  output logic [CNT_W-1:0] cnt_ref
);

  localparam logic [2:0] C_NOP = 3'd0;
  localparam logic [2:0] C_ACT = 3'd1;
  localparam logic [2:0] C_RD  = 3'd2;
  localparam logic [2:0] C_WR  = 3'd3;
  localparam logic [2:0] C_PRE = 3'd4;
  localparam logic [2:0] C_REF = 3'd5;
  localparam logic [2:0] C_LMR = 3'd6;
  localparam logic [2:0] C_BST = 3'd7;

  // Timers are 4 bits and saturate at 15, so spacings up to 15 are exact.
  if (TRCD < 1 || TRCD > 15 || TRP < 1 || TRP > 15) begin : g_bad_param
    $error("sdr_cmd_monitor: TRCD and TRP must be in 1..15");
  end

  logic [2:0]       dec_code;
  logic [2:0]       err_d;
  logic [3:0]       bank_d;
  logic             is_rdwr;

  logic             cmd_valid_q;
  logic [2:0]       cmd_code_q;
  logic [1:0]       cmd_ba_q;
  logic [12:0]      cmd_addr_q;
  logic [3:0]       bank_open_q;
  logic             err_valid_q;
  logic [2:0]       err_code_q;
  logic             err_sticky_q;
  logic [CNT_W-1:0] cnt_act_q, cnt_rd_q, cnt_wr_q, cnt_ref_q;

  // Decode the sampled pins into a command code (deselect counts as NOP).
  always_comb begin
    dec_code = C_NOP;
    if (!sdr_cs_n) begin
      case ({sdr_ras_n, sdr_cas_n, sdr_we_n})
        3'b011:  dec_code = C_ACT;
        3'b101:  dec_code = C_RD;
        3'b100:  dec_code = C_WR;
        3'b010:  dec_code = C_PRE;
        3'b001:  dec_code = C_REF;
        3'b000:  dec_code = C_LMR;
        3'b110:  dec_code = C_BST;
        default: dec_code = C_NOP;
      endcase
    end
  end

  assign is_rdwr = (dec_code == C_RD) || (dec_code == C_WR);

`ifdef SDR_MON_TIMING_CHK_EN
  localparam logic [3:0] TRCD_L = 4'(TRCD);
  localparam logic [3:0] TRP_L  = 4'(TRP);

  // Each timer holds the clock count since its starting command, saturating
  // at 15; reset leaves them saturated so nothing looks too recent.
  logic [3:0] trcd_tmr_q [4];
  logic [3:0] trp_tmr_q  [4];

  // Per-bank tRCD (from ACTIVE) and tRP (from any precharge) timers.
  always_ff @(posedge sdram_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (!sdram_resetn) begin
        trcd_tmr_q[b] <= 4'hF;
        trp_tmr_q[b]  <= 4'hF;
      end else begin
        if (dec_code == C_ACT && sdr_ba == 2'(b))
          trcd_tmr_q[b] <= 4'd1;
        else if (trcd_tmr_q[b] != 4'hF)
          trcd_tmr_q[b] <= trcd_tmr_q[b] + 4'd1;

        if ((dec_code == C_PRE && (sdr_addr[10] || sdr_ba == 2'(b))) ||
            (is_rdwr && sdr_addr[10] && sdr_ba == 2'(b)))
          trp_tmr_q[b] <= 4'd1;
        else if (trp_tmr_q[b] != 4'hF)
          trp_tmr_q[b] <= trp_tmr_q[b] + 4'd1;
      end
    end
  end
`endif

  // Classify the current command; lower error codes take priority.
  always_comb begin
    err_d = 3'd0;
    case (dec_code)
      C_ACT: begin
        if (bank_open_q[sdr_ba]) err_d = 3'd1;
`ifdef SDR_MON_TIMING_CHK_EN
        else if (trp_tmr_q[sdr_ba] < TRP_L) err_d = 3'd4;
`endif
      end
      C_RD, C_WR: begin
        if (!bank_open_q[sdr_ba]) err_d = 3'd2;
`ifdef SDR_MON_TIMING_CHK_EN
        else if (trcd_tmr_q[sdr_ba] < TRCD_L) err_d = 3'd3;
`endif
      end
      C_REF, C_LMR: begin
        if (|bank_open_q) err_d = 3'd5;
      end
      default: err_d = 3'd0;
    endcase
  end

  // Next bank-open state; applied even when the command is in error.
  always_comb begin
    bank_d = bank_open_q;
    case (dec_code)
      C_ACT: bank_d[sdr_ba] = 1'b1;
      C_PRE: begin
        if (sdr_addr[10]) bank_d = 4'b0000;
        else              bank_d[sdr_ba] = 1'b0;
      end
      C_RD, C_WR: if (sdr_addr[10]) bank_d[sdr_ba] = 1'b0;
      default: bank_d = bank_open_q;
    endcase
  end

  // Register decode results, bank state, sticky error and counters.
  always_ff @(posedge sdram_clk) begin
    if (!sdram_resetn) begin
      cmd_valid_q  <= 1'b0;
      cmd_code_q   <= 3'd0;
      cmd_ba_q     <= 2'd0;
      cmd_addr_q   <= 13'd0;
      bank_open_q  <= 4'b0000;
      err_valid_q  <= 1'b0;
      err_code_q   <= 3'd0;
      err_sticky_q <= 1'b0;
      cnt_act_q    <= '0;
      cnt_rd_q     <= '0;
      cnt_wr_q     <= '0;
      cnt_ref_q    <= '0;
    end else begin
      cmd_valid_q <= (dec_code != C_NOP);
      cmd_code_q  <= dec_code;
      if (dec_code != C_NOP) begin
        cmd_ba_q   <= sdr_ba;
        cmd_addr_q <= sdr_addr;
      end
      bank_open_q <= bank_d;
      err_valid_q <= (err_d != 3'd0);
      err_code_q  <= err_d;
      // A coincident clear beats both counting and the sticky flag.
      if (stat_clr) begin
        err_sticky_q <= 1'b0;
        cnt_act_q    <= '0;
        cnt_rd_q     <= '0;
        cnt_wr_q     <= '0;
        cnt_ref_q    <= '0;
      end else begin
        err_sticky_q <= err_sticky_q | (err_d != 3'd0);
        if (dec_code == C_ACT && cnt_act_q != '1) cnt_act_q <= cnt_act_q + 1'b1;
        if (dec_code == C_RD  && cnt_rd_q  != '1) cnt_rd_q  <= cnt_rd_q  + 1'b1;
        if (dec_code == C_WR  && cnt_wr_q  != '1) cnt_wr_q  <= cnt_wr_q  + 1'b1;
        if (dec_code == C_REF && cnt_ref_q != '1) cnt_ref_q <= cnt_ref_q + 1'b1;
      end
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_code   = cmd_code_q;
  assign cmd_ba     = cmd_ba_q;
  assign cmd_addr   = cmd_addr_q;
  assign bank_open  = bank_open_q;
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign err_sticky = err_sticky_q;
  assign cnt_act    = cnt_act_q;
  assign cnt_rd     = cnt_rd_q;
  assign cnt_wr     = cnt_wr_q;
  assign cnt_ref    = cnt_ref_q;

endmodule
